// File: rtl/audio_pkg.sv
// Shared types for the audio output path.
// Sample width matches the register file's R6 audio port.
package audio_pkg;
    localparam int AUDIO_W = 11;
    typedef logic [AUDIO_W-1:0] audio_sample_t;
    typedef enum logic [1:0] {
        IDLE,
        PLAYING,
        DRAIN,
        DONE
    } playback_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head and an explicit level counter.
// A push while full is taken only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      level_q, level_d;
    logic             wr_en, rd_en;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign rdata = mem_q[rd_q];
    assign level = level_q;

    always_comb begin
        rd_en   = pop & ~empty;
        wr_en   = push & (~full | rd_en);
        wr_d    = wr_q + AW'(wr_en);
        rd_d    = rd_q + AW'(rd_en);
        level_d = level_q;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset; the level counter defines what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/audio_out_buffer.sv
// Buffers register-file audio samples and plays them to the DAC at a fixed rate.
// Reports backpressure, sticky under/overflow and end of playback.
module audio_out_buffer
    import audio_pkg::*;
#(
    parameter int DATA_W  = AUDIO_W,
    parameter int DEPTH   = 16,
    parameter int CLK_DIV = 2268,
    parameter int PREFILL = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      sample_in,
    input  logic                   sample_req,
    input  logic                   finish_in,
    output logic                   space_avail,
    output logic [DATA_W-1:0]      dac_data,
    output logic                   dac_strobe,
    output logic [$clog2(DEPTH):0] level,
    output logic                   underrun,
    output logic                   overflow,
    output logic                   done
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int LW = $clog2(DEPTH) + 1;

    playback_state_t   state_q, state_d;
    logic              req_q, req_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic              dac_strobe_q, dac_strobe_d;
    logic              underrun_q, underrun_d;
    logic              overflow_q, overflow_d;

    logic              live, tick, push, pop, push_ok;
    logic [DATA_W-1:0] head;
    logic              full, empty;
    logic [LW-1:0]     fifo_level;

    assign live    = (state_q != DONE);
    assign tick    = live & (cnt_q == CW'(CLK_DIV - 1));
    assign push    = sample_req & ~req_q & live;
    assign pop     = tick & ~empty
                   & (state_q == PLAYING || state_q == DRAIN);
    assign push_ok = push & (~full | pop);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (sample_in),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        req_d        = sample_req;
        cnt_d        = cnt_q;
        if (live) cnt_d = tick ? '0 : cnt_q + 1'b1;
        dac_strobe_d = pop;
        dac_data_d   = pop ? head : dac_data_q;
        underrun_d   = underrun_q
                     | (tick & empty & (state_q == PLAYING));
        overflow_d   = overflow_q | (push & full & ~pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q        <= 1'b0;
            cnt_q        <= '0;
            dac_data_q   <= '0;
            dac_strobe_q <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            dac_data_q   <= dac_data_d;
            dac_strobe_q <= dac_strobe_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Prefill is judged on the level including this cycle's push.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fifo_level + LW'(push_ok) >= LW'(PREFILL)
                    || finish_in)
                    state_d = PLAYING;
            end
            PLAYING: if (finish_in) state_d = DRAIN;
            DRAIN:   if (tick & empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done        = (state_q == DONE);
        space_avail = (fifo_level < LW'(DEPTH));
        level       = fifo_level;
        dac_data    = dac_data_q;
        dac_strobe  = dac_strobe_q;
        underrun    = underrun_q;
        overflow    = overflow_q;
    end
endmodule

// File: tb/tb_audio_out_buffer.sv
// Scoreboard bench for audio_out_buffer against a queue-based playback model.
// Directed scenarios are followed by randomized push traffic.
module tb_audio_out_buffer;
    localparam int DW      = 11;
    localparam int DEPTH   = 16;
    localparam int CLK_DIV = 40;
    localparam int PREFILL = 8;
    localparam int LW      = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] sample_in = '0;
    logic          sample_req = 1'b0;
    logic          finish_in = 1'b0;
    logic          space_avail;
    logic [DW-1:0] dac_data;
    logic          dac_strobe;
    logic [LW-1:0] level;
    logic          underrun;
    logic          overflow;
    logic          done;

    always #5 clk = ~clk;

    audio_out_buffer #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .CLK_DIV (CLK_DIV),
        .PREFILL (PREFILL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_req  (sample_req),
        .finish_in   (finish_in),
        .space_avail (space_avail),
        .dac_data    (dac_data),
        .dac_strobe  (dac_strobe),
        .level       (level),
        .underrun    (underrun),
        .overflow    (overflow),
        .done        (done)
    );

    // Model: phase 0 idle, 1 playing, 2 draining, 3 finished.
    int mq[$];
    int exp_q[$];
    int m_cnt = 0;
    int m_phase = 0;
    int m_dac = 0;
    int m_pre;
    bit m_req = 0, m_strobe = 0, m_ovf = 0, m_unf = 0;
    bit m_tick, m_push;

    int checks = 0;
    int passes = 0;
    int cyc_n = 0;
    int strobe_cnt = 0;
    int last_strobe = 0;
    bit have_last = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            exp_q.delete();
            m_cnt = 0;
            m_phase = 0;
            m_dac = 0;
            m_req = 0;
            m_strobe = 0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            m_pre  = mq.size();
            m_tick = (m_cnt == CLK_DIV - 1) && (m_phase != 3);
            m_push = sample_req && !m_req && (m_phase != 3);
            m_strobe = 0;
            if (m_tick && m_pre > 0 && (m_phase == 1 || m_phase == 2)) begin
                m_dac = mq.pop_front();
                exp_q.push_back(m_dac);
                m_strobe = 1;
            end
            if (m_push) begin
                if (mq.size() < DEPTH) mq.push_back(int'(sample_in));
                else m_ovf = 1;
            end
            if (m_phase != 3) m_cnt = m_tick ? 0 : m_cnt + 1;
            case (m_phase)
                0: if (mq.size() >= PREFILL || finish_in) m_phase = 1;
                1: begin
                    if (m_tick && m_pre == 0) m_unf = 1;
                    if (finish_in) m_phase = 2;
                end
                2: if (m_tick && m_pre == 0) m_phase = 3;
                default: ;
            endcase
            m_req = sample_req;
        end
    end

    always @(negedge clk) begin
        cyc_n++;
        if (!rst) begin
            have_last = 0;
        end else begin
            chk("strobe", int'(dac_strobe), int'(m_strobe));
            if (dac_strobe) begin
                strobe_cnt++;
                if (exp_q.size() == 0) chk("strobe_unexpected", 1, 0);
                else chk("dac_sample", int'(dac_data), exp_q.pop_front());
                if (have_last)
                    chk("strobe_spacing", (cyc_n - last_strobe) % CLK_DIV, 0);
                last_strobe = cyc_n;
                have_last = 1;
            end
            chk("dac_hold", int'(dac_data), m_dac);
            chk("level", int'(level), mq.size());
            chk("space_avail", int'(space_avail), int'(mq.size() < DEPTH));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underrun", int'(underrun), int'(m_unf));
            chk("done", int'(done), int'(m_phase == 3));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        sample_req = 1'b0;
        finish_in = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic push_edge(input int d);
        @(negedge clk);
        sample_req = 1'b1;
        sample_in = DW'(d);
        @(negedge clk);
        sample_req = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", int'(done), 1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_strobe"}, int'(dac_strobe), 0);
        chk({tag, "_data"}, int'(dac_data), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_unf"}, int'(underrun), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_space"}, int'(space_avail), 1);
    endtask

    initial begin
        int n;
        int pct;
        int s0;

        // Request held high across reset release gives one push.
        sample_req = 1'b1;
        sample_in = 11'h155;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        #2 rst = 1'b1;
        @(negedge clk);
        chk("first_push_level", int'(level), 1);
        chk("first_push_ovf", int'(overflow), 0);
        sample_req = 1'b0;

        // Prefill then play 1..8.
        do_reset();
        for (int i = 1; i <= 8; i++) push_edge(i);
        strobe_cnt = 0;
        n = 0;
        while (strobe_cnt < 8 && n < 9 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        chk("eight_strobes", strobe_cnt, 8);
        repeat (CLK_DIV + 2) @(negedge clk);
        chk("underrun_after_empty", int'(underrun), 1);
        chk("still_playing", int'(done), 0);

        // Fill to 16, then one dropped push.
        do_reset();
        for (int i = 0; i < 16; i++) push_edge(int'($urandom_range(0, 2047)));
        chk("full_level", int'(level), 16);
        chk("full_space", int'(space_avail), 0);
        chk("full_no_ovf", int'(overflow), 0);
        push_edge(11'h3FF);
        chk("drop_ovf", int'(overflow), 1);
        chk("drop_level", int'(level), 16);

        // Push coincident with a tick while full.
        do_reset();
        for (int i = 0; i < 16; i++) push_edge(16'h100 + i);
        n = 0;
        while (m_cnt != CLK_DIV - 1 && n < 4 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        sample_req = 1'b1;
        sample_in = 11'h7AB;
        @(negedge clk);
        sample_req = 1'b0;
        chk("tick_push_level", int'(level), 16);
        chk("tick_push_ovf", int'(overflow), 0);
        chk("tick_push_strobe", int'(dac_strobe), 1);
        chk("tick_push_head", int'(dac_data), 16'h100);

        // Finish with three entries, then pushes are ignored.
        do_reset();
        for (int i = 0; i < 3; i++) push_edge(int'($urandom_range(0, 2047)));
        @(negedge clk);
        finish_in = 1'b1;
        strobe_cnt = 0;
        wait_done(6 * CLK_DIV);
        chk("drain_strobes", strobe_cnt, 3);
        s0 = int'(dac_data);
        push_edge(11'h011);
        push_edge(11'h022);
        chk("done_ignores_level", int'(level), 0);
        chk("done_ignores_ovf", int'(overflow), 0);
        chk("done_holds_data", int'(dac_data), s0);

        // Reset in the middle of a drain.
        do_reset();
        for (int i = 0; i < 10; i++) push_edge(int'($urandom_range(0, 2047)));
        finish_in = 1'b1;
        repeat (CLK_DIV + 5) @(negedge clk);
        chk("mid_drain_busy", int'(level > 0), 1);
        #2 rst = 1'b0;
        #1;
        check_cleared("mid_drain");
        finish_in = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;

        // Randomized traffic with varying request density.
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            case (blk % 3)
                0: pct = 2;
                1: pct = 45;
                default: pct = 6;
            endcase
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                sample_req = ($urandom_range(0, 99) < pct);
                sample_in = DW'($urandom_range(0, 2047));
            end
        end
        @(negedge clk);
        sample_req = 1'b0;
        finish_in = 1'b1;
        wait_done((DEPTH + 3) * CLK_DIV);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
